// File: rtl/wb_sel_ctrl.sv
// Writeback-select controller: retires one opcode at a time through
// DECODE/EXEC/(MEMWAIT)/WB and drives the 4:1 writeback mux select.
module wb_sel_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] opcode,
    input  logic       mem_done,
    output logic [1:0] sel,
    output logic       reg_wen,
    output logic       illegal,
    output logic       timeout,
    output logic [7:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEMWAIT,
        S_WB
    } state_t;

    localparam logic [7:0] OP_LOAD   = 8'h03;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] opc_q;
    logic [7:0] wait_cnt;
    logic [2:0] dec;
    logic       dec_legal;
    logic       is_load;
    logic       wait_expired;

    // Returns {legal, sel} for an opcode.
    function automatic logic [2:0] decode_op(input logic [7:0] op);
        logic [2:0] r;
        case (op)
            8'h00, 8'h01: r = 3'b1_00;
            8'h02:        r = 3'b1_01;
            8'h03:        r = 3'b1_10;
            8'h04:        r = 3'b1_11;
            default:      r = 3'b0_00;
        endcase
        return r;
    endfunction

    assign dec          = decode_op(opc_q);
    assign dec_legal    = dec[2];
    assign is_load      = (opc_q == OP_LOAD);
    assign wait_expired = (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (instr_valid) state_nxt = S_DECODE;
            S_DECODE:  state_nxt = dec_legal ? S_EXEC : S_IDLE;
            S_EXEC:    state_nxt = is_load ? S_MEMWAIT : S_WB;
            S_MEMWAIT: begin
                // mem_done wins over an expiring wait counter
                if (mem_done) begin
                    state_nxt = S_WB;
                end else if (wait_expired) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WB:      state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        instr_ready = (state == S_IDLE);
        reg_wen     = (state == S_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q       <= 8'h00;
            sel         <= 2'b00;
            wait_cnt    <= 8'h00;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            retired_cnt <= 8'h00;
        end else begin
            if (state == S_IDLE && instr_valid) begin
                opc_q <= opcode;
            end
            if (state == S_DECODE && dec_legal) begin
                sel <= dec[1:0];
            end
            if (state == S_EXEC) begin
                wait_cnt <= 8'h00;
            end else if (state == S_MEMWAIT && !mem_done) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // Pulses land in the IDLE cycle that follows the abort
            illegal <= (state == S_DECODE) && !dec_legal;
            timeout <= (state == S_MEMWAIT) && !mem_done && wait_expired;
            if (state == S_WB) begin
                retired_cnt <= retired_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/wb_sel_ctrl.md
WB_SEL_CTRL -- requirements
Module: wb_sel_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the max MEMWAIT cycles allowed for a load (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port instr_valid, input, 1, opcode presented.
REQ-005 SHALL have port instr_ready, output, 1, block can accept an opcode.
REQ-006 SHALL have port opcode, input, 8, instruction class to retire.
REQ-007 SHALL have port mem_done, input, 1, memory read data available.
REQ-008 SHALL have port sel, output, 2, select to the downstream 4:1 writeback mux (sel[1]=S1, sel[0]=S0).
REQ-009 SHALL have port reg_wen, output, 1, register-file write strobe.
REQ-010 SHALL have port illegal, output, 1, one-cycle pulse on undefined opcode.
REQ-011 SHALL have port timeout, output, 1, one-cycle pulse on load timeout.
REQ-012 SHALL have port retired_cnt, output, 8, count of completed writebacks.

Function
REQ-013 SHALL implement states IDLE, DECODE, EXEC, MEMWAIT, WB; all outputs registered or decoded from registered state only.
REQ-014 SHALL drive instr_ready=1 exactly when state is IDLE.
REQ-015 SHALL accept (latch opcode, go DECODE) in cycle T when instr_valid=1 and instr_ready=1; instr_valid in other states is ignored.
REQ-016 SHALL decode: 0x00 ADD, 0x01 SUB -> sel 00 (ALU); 0x02 LOADI -> sel 01 (immediate); 0x03 LOAD -> sel 10 (memory); 0x04 MOV -> sel 11 (register); all other values illegal.
REQ-017 SHALL update sel on the DECODE->EXEC transition for legal opcodes and hold it through WB and subsequent IDLE until the next legal decode.
REQ-018 SHALL, for non-load legal opcodes, follow DECODE(T+1) -> EXEC(T+2) -> WB(T+3) -> IDLE(T+4).
REQ-019 SHALL, for LOAD, go EXEC -> MEMWAIT, remaining in MEMWAIT until mem_done=1, then WB next cycle.
REQ-020 SHALL sample mem_done only in MEMWAIT; mem_done in any other state is ignored and not remembered.
REQ-021 SHALL clear an 8-bit wait counter on MEMWAIT entry and increment it for each MEMWAIT cycle with mem_done=0.
REQ-022 SHALL, when counter equals MEM_TIMEOUT-1 and mem_done=0, go IDLE without WB and pulse timeout=1 in the first IDLE cycle.
REQ-023 SHALL give mem_done priority over timeout when both occur in the same cycle (go WB).
REQ-024 SHALL, on illegal opcode in DECODE, go IDLE next cycle, pulse illegal=1 in that IDLE cycle, leave sel unchanged, and not assert reg_wen.
REQ-025 SHALL assert reg_wen=1 for exactly the single WB cycle, never otherwise.
REQ-026 SHALL increment retired_cnt by 1 in each WB cycle, wrapping 255 -> 0 without flag.
REQ-027 SHALL ensure illegal and timeout are never both 1 in the same cycle.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE, sel=00, reg_wen=0, illegal=0, timeout=0, retired_cnt=0, wait counter=0, latched opcode=0x00.
REQ-029 SHALL abort any in-flight instruction on reset assertion, with no reg_wen and no count update for it.
REQ-030 SHALL present instr_ready=1 in the first cycle after rst_n deasserts.

Verification
REQ-031 Bench: reset, send ADD (0x00) at T -> instr_ready=0 T+1..T+3, sel=00 from T+2, reg_wen=1 only at T+3, retired_cnt=1, instr_ready=1 at T+4.
REQ-032 Bench: send LOAD (0x03), mem_done=1 on 3rd MEMWAIT cycle -> sel=10, reg_wen=1 one cycle after that mem_done, retired_cnt +1.
REQ-033 Bench: LOAD with mem_done held 0, MEM_TIMEOUT=15 -> 15 MEMWAIT cycles, then IDLE with timeout=1 for one cycle, no reg_wen, retired_cnt unchanged; repeat with mem_done=1 on 15th cycle -> WB, no timeout.
REQ-034 Bench: send MOV (sel 11) then opcode 0x7F -> illegal=1 one cycle, sel stays 11, reg_wen stays 0.
REQ-035 Bench: 256 back-to-back LOADI (0x02) -> retired_cnt wraps to 0x00, sel=01 throughout after first decode.
REQ-036 Bench: assert rst_n=0 mid-MEMWAIT, off clock edge -> outputs reach reset values without a clock edge; later mem_done pulse has no effect; instr_ready=1 after release.
